// File: rtl/p4_router_page_alloc_arbiter.sv
// Page allocation / free arbiter in front of the queue MMU: round-robin page grants
// with MTU-based packet admission, plus a round-robin merge of page returns.
module p4_router_page_alloc_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_PAGES_LOG = 10,
  parameter int PAGE_BYTES    = 256,
  parameter int MTU_BYTES     = 2000
) (
  input  logic                               clk,
  input  logic                               sresetn,
  input  logic [NUM_PAGES_LOG:0]             num_free_pages,
  input  logic                               mmu_malloc_tvalid,
  output logic                               mmu_malloc_tready,
  input  logic [NUM_PAGES_LOG-1:0]           mmu_malloc_tdata,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_sop,
  input  logic [NUM_REQ-1:0]                 req_eop,
  output logic [NUM_REQ-1:0]                 grant_valid,
  output logic [NUM_PAGES_LOG-1:0]           grant_page,
  input  logic [NUM_REQ-1:0]                 free_valid,
  output logic [NUM_REQ-1:0]                 free_ready,
  input  logic [NUM_REQ*NUM_PAGES_LOG-1:0]   free_page,
  output logic                               mmu_free_tvalid,
  input  logic                               mmu_free_tready,
  output logic [NUM_PAGES_LOG-1:0]           mmu_free_tdata,
  output logic [$clog2(NUM_REQ+1)-1:0]       active_pkts,
  output logic                               admit_stall,
  output logic                               proto_err
);

  localparam int MTU_PAGES = (MTU_BYTES + PAGE_BYTES - 1) / PAGE_BYTES;
  localparam int CNT_W     = $clog2(NUM_REQ + 1);
  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int PROD_W    = NUM_PAGES_LOG + CNT_W + 4;

  logic [NUM_REQ-1:0]       r_in_pkt;
  logic [IDX_W-1:0]         r_rr_alloc;
  logic [IDX_W-1:0]         r_rr_free;
  logic [NUM_REQ-1:0]       r_grant_valid;
  logic [NUM_PAGES_LOG-1:0] r_grant_page;
  logic                     r_free_valid;
  logic [NUM_PAGES_LOG-1:0] r_free_data;
  logic                     r_proto_err;

  logic [CNT_W-1:0]  w_active;
  logic [PROD_W-1:0] w_need;
  logic              w_admit_ok;
  logic [NUM_REQ-1:0] w_req_m;
  logic [NUM_REQ-1:0] w_elig;
  logic [IDX_W:0]    w_alloc_pick;
  logic [IDX_W:0]    w_free_pick;
  logic              w_alloc_found;
  logic [IDX_W-1:0]  w_alloc_idx;
  logic              w_free_found;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_free_take;

  // First set bit of elig at or after start (with wrap); MSB of the result is "found".
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [IDX_W-1:0]   start);
    logic [IDX_W:0] res;
    int j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (elig[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < NUM_REQ; i++) w_active = w_active + CNT_W'(r_in_pkt[i]);
  end

  // Reserve a full MTU of pages for every open packet plus the one being admitted.
  assign w_need     = (PROD_W'(w_active) + PROD_W'(1)) * PROD_W'(MTU_PAGES);
  assign w_admit_ok = PROD_W'(num_free_pages) >= w_need;

  // A requester just granted must not be served again in the grant-pulse cycle.
  assign w_req_m = req_valid & ~r_grant_valid;
  assign w_elig  = w_req_m & {NUM_REQ{mmu_malloc_tvalid}} & (r_in_pkt | {NUM_REQ{w_admit_ok}});

  assign w_alloc_pick  = rr_pick(w_elig, r_rr_alloc);
  assign w_alloc_found = w_alloc_pick[IDX_W];
  assign w_alloc_idx   = w_alloc_pick[IDX_W-1:0];

  assign w_free_pick  = rr_pick(free_valid, r_rr_free);
  assign w_free_found = w_free_pick[IDX_W];
  assign w_free_idx   = w_free_pick[IDX_W-1:0];
  assign w_free_take  = !r_free_valid || mmu_free_tready;

  assign mmu_malloc_tready = sresetn && w_alloc_found;
  assign free_ready        = (sresetn && w_free_found && w_free_take) ?
                             (NUM_REQ'(1) << w_free_idx) : '0;
  assign admit_stall       = sresetn && mmu_malloc_tvalid && !w_admit_ok &&
                             (|(w_req_m & ~r_in_pkt));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_in_pkt      <= '0;
      r_rr_alloc    <= '0;
      r_rr_free     <= '0;
      r_grant_valid <= '0;
      r_grant_page  <= '0;
      r_free_valid  <= 1'b0;
      r_free_data   <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_grant_valid <= '0;
      r_grant_page  <= '0;
      if (w_alloc_found) begin
        r_grant_valid[w_alloc_idx] <= 1'b1;
        r_grant_page               <= mmu_malloc_tdata;
        // sop on an open packet continues it; a continuation on a closed one opens it.
        r_in_pkt[w_alloc_idx]      <= !req_eop[w_alloc_idx];
        if (req_sop[w_alloc_idx] == r_in_pkt[w_alloc_idx]) r_proto_err <= 1'b1;
        r_rr_alloc <= rr_next(w_alloc_idx);
      end
      if (w_free_take) begin
        r_free_valid <= w_free_found;
        if (w_free_found) begin
          r_free_data <= free_page[int'(w_free_idx)*NUM_PAGES_LOG +: NUM_PAGES_LOG];
          r_rr_free   <= rr_next(w_free_idx);
        end
      end
    end
  end

  assign grant_valid     = r_grant_valid;
  assign grant_page      = r_grant_page;
  assign mmu_free_tvalid = r_free_valid;
  assign mmu_free_tdata  = r_free_data;
  assign active_pkts     = w_active;
  assign proto_err       = r_proto_err;

endmodule

// File: doc/p4_router_page_alloc_arbiter.md
# p4_router_page_alloc_arbiter

Shares the router queue MMU's single page-allocation stream and single page-free stream among `NUM_REQ` packet-buffer requesters (per-ingress write engines and egress read engines). Allocation is round-robin per page. A new packet is admitted only while the free-page count still guarantees an MTU-sized completion for every packet already in progress, so no started packet can starve for pages. Sits between the ingress/egress buffer engines and the queue MMU.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `NUM_PAGES_LOG`, 10: log2 of MMU page count; page pointer width.
- `PAGE_BYTES`, 256: bytes per page.
- `MTU_BYTES`, 2000: largest packet; `MTU_PAGES = ceil(MTU_BYTES/PAGE_BYTES)` (8 at defaults).

Ports:
- `clk` in 1: single clock.
- `sresetn` in 1: synchronous, active-low reset.
- `num_free_pages` in `NUM_PAGES_LOG+1`: current MMU free-page count.
- `mmu_malloc_tvalid` in 1, `mmu_malloc_tready` out 1, `mmu_malloc_tdata` in `NUM_PAGES_LOG`: page pointers from the MMU.
- `req_valid`, `req_sop`, `req_eop` in `NUM_REQ`: per-requester page request; the request is the first page and/or last page of a packet.
- `grant_valid` out `NUM_REQ`: one-hot grant pulse.
- `grant_page` out `NUM_PAGES_LOG`: granted pointer, shared by all requesters.
- `free_valid` in `NUM_REQ`, `free_ready` out `NUM_REQ`, `free_page` in `NUM_REQ*NUM_PAGES_LOG`: per-requester page returns; requester i occupies slice i.
- `mmu_free_tvalid` out 1, `mmu_free_tready` in 1, `mmu_free_tdata` out `NUM_PAGES_LOG`: merged returns to the MMU.
- `active_pkts` out `$clog2(NUM_REQ+1)`: packets currently in progress.
- `admit_stall` out 1: a start-of-packet request is blocked by admission this cycle.
- `proto_err` out 1: sticky protocol error.

## Operation
- **Per-requester state.** Each requester has an `in_pkt[i]` flag. `active_pkts` is the popcount of `in_pkt`.
- **Admission.** `admit_ok = num_free_pages >= (active_pkts+1)*MTU_PAGES`. Compute the product at width `NUM_PAGES_LOG+$clog2(NUM_REQ+1)+4` with no truncation.
- **Eligibility.** Requester i is eligible when all of these hold:
  - `req_valid[i]`.
  - `mmu_malloc_tvalid`.
  - `in_pkt[i]` is set, or `admit_ok`.
- **Allocation arbitration.**
  - Round-robin among eligible requesters, starting at `rr_alloc` and searching in increasing index with wrap.
  - `mmu_malloc_tready` is asserted combinationally only when a winner exists.
  - On handshake, `rr_alloc` becomes winner+1, wrapping modulo `NUM_REQ`.
- **`in_pkt` update on grant to i.**
  - sop & !eop: set.
  - eop: clear. A single-page packet (sop & eop) never sets `in_pkt`.
  - !sop & !eop with `in_pkt` set: unchanged.
- **Protocol errors.** Set `proto_err` when either occurs:
  - sop is granted while `in_pkt[i]` is set: the request is treated as a continuation.
  - !sop is granted while `in_pkt[i]` is clear: the request is treated as sop and is subject to admission.
  - `proto_err` clears only on reset.
- **`admit_stall`.** Equals 1 when any `req_valid[i]` with `in_pkt[i]` clear is blocked only because `admit_ok` is 0.
- **Free path.**
  - Independent round-robin (`rr_free`) over `free_valid`, feeding a one-entry output register.
  - `free_ready[i]` is 1 only for the winner, and only when `!mmu_free_tvalid | mmu_free_tready`.
  - The register loads the winner's slice; `mmu_free_tvalid` drops when drained with no new winner.
- **AXIS rule.** `mmu_free_tdata` is stable while `mmu_free_tvalid & !mmu_free_tready`.
- **Requester obligation.** Each requester holds `req_valid` and its flags until its grant pulse. It must not re-request in the cycle it receives `grant_valid`; the arbiter ignores such a request for that cycle.

## Timing
- **Reset values.** All outputs reset to 0. `in_pkt`, `rr_alloc`, `rr_free` and the free register all clear to 0.
- **Reset mid-packet.** Tracking is dropped; page-pool recovery is the parent's responsibility.
- **Grant latency.** The malloc handshake at cycle N produces `grant_valid[i]` (one cycle) and `grant_page` at N+1. `grant_page` is 0 when no grant is active.
- **Throughput.** One allocation and one free per cycle, concurrently.
- **Free latency.** `free_valid`/`free_ready` handshake at N puts the page on `mmu_free_tdata` at N+1.
- **Status timing.** `active_pkts` updates in the cycle after the grant.
- **Admission input.** Admission uses the current-cycle `num_free_pages`. The MMU's count lag is covered by the whole-MTU reservation per active packet.
- **Simultaneous sop and eop.** When a sop and an eop are granted in consecutive cycles, the next admission decision sees the updated `active_pkts`.

## Test plan
- **Fair allocation.** All 4 requesting continuation pages, `in_pkt` all set, MMU supplies pointers 0..7 back-to-back → grants in order 0,1,2,3,0,1,2,3 with pages 0..7, one per cycle, 1-cycle latency.
- **Admission block.** `num_free_pages`=16, 1 active packet, requester 2 sop → admitted (16≥16). With 2 active → blocked, `admit_stall`=1, no tready. Raise the count to 24 → granted the next cycle.
- **Single-page packet.** Sop&eop grant → `active_pkts` unchanged, `proto_err`=0.
- **Free merge.** All 4 `free_valid` with pages 0x10..0x13, `mmu_free_tready` low 3 cycles → data held at 0x10. Then 0x10..0x13 drain in round-robin order, 1 per cycle.
- **Protocol error.** Continuation request with `in_pkt` clear → treated as sop, `proto_err`=1 and sticky until `sresetn`.
- **Reset mid-packet.** Drive `sresetn`=0 for 1 cycle with 3 packets active → `active_pkts`=0 and all outputs 0 the next cycle. The next request requires sop admission.
